// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the parameterised data memory
package dmem_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} wr_mode_e;
    typedef enum logic {INIT, IDLE} dmem_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/dmem_rd_pipe.sv
// rtl/dmem_rd_pipe.sv - read-return pipeline of LAT stages; data only advances with valid
module dmem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    vld;
    logic [DATA_W-1:0] dat [LAT];

    // Data registers load only alongside a valid, so the output holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/param_dmem.sv
// rtl/param_dmem.sv - byte-enabled data memory with one write port and NRD read ports
module param_dmem
    import dmem_pkg::*;
#(
    parameter int       DATA_W  = 32,
    parameter int       ADDR_W  = 32,
    parameter int       DEPTH   = 256,
    parameter int       NRD     = 2,
    parameter int       RD_LAT  = 1,
    parameter wr_mode_e WR_MODE = READ_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rvalid,
    output logic                  ready,
    output logic                  err
);

    localparam int BE_W = DATA_W / BYTE_W;
    localparam int OFF  = $clog2(BE_W);
    localparam int AW   = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    dmem_state_e       state;
    logic [AW:0]       init_cnt;

    logic [ADDR_W-1:0] widx;
    logic              w_in;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_word;
    logic [NRD-1:0]    rd_rej;

    // Range check uses every index bit so high addresses never alias low words.
    assign widx  = waddr >> OFF;
    assign w_in  = (widx >> AW) == '0;
    assign wr_ok = wr_en && ready && w_in;

    always_comb begin
        wr_word = mem[widx[AW-1:0]];
        for (int b = 0; b < BE_W; b++) begin
            if (wbe[b]) wr_word[b*BYTE_W +: BYTE_W] = wdata[b*BYTE_W +: BYTE_W];
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [ADDR_W-1:0] ridx;
            logic              r_in;
            logic              hit;
            logic [DATA_W-1:0] word;

            assign ridx      = raddr[k*ADDR_W +: ADDR_W] >> OFF;
            assign r_in      = (ridx >> AW) == '0;
            assign hit       = (WR_MODE == WRITE_FIRST) && wr_ok && (ridx == widx);
            assign word      = !r_in ? '0 : (hit ? wr_word : mem[ridx[AW-1:0]]);
            assign rd_rej[k] = rd_en[k] && !(ready && r_in);

            dmem_rd_pipe #(.DATA_W(DATA_W), .LAT(RD_LAT)) u_pipe (
                .clk      (clk),
                .reset    (reset),
                .in_valid (rd_en[k] && ready),
                .in_data  (word),
                .out_valid(rvalid[k]),
                .out_data (rdata[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                if (!init_cnt[AW]) mem[init_cnt[AW-1:0]] <= '0;
            end else if (wr_ok) begin
                mem[widx[AW-1:0]] <= wr_word;
            end
        end
    end

    // The extra counter bit marks "all words cleared"; IDLE follows one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= (wr_en && !(ready && w_in)) || (|rd_rej);
            case (state)
                INIT: begin
                    if (init_cnt[AW]) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: ;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_param_dmem.sv
// tb/tb_param_dmem.sv - scoreboard bench for param_dmem (READ_FIRST/lat1 and WRITE_FIRST/lat2)
module tb_param_dmem;
    import dmem_pkg::*;

    logic        clk;
    logic        reset, wr_en;
    logic [31:0] waddr, wdata;
    logic [3:0]  wbe;
    logic [1:0]  rd_en, rvalid;
    logic [63:0] raddr, rdata;
    logic        ready, err;

    logic        reset2, wr_en2;
    logic [31:0] waddr2, wdata2;
    logic [3:0]  wbe2;
    logic [1:0]  rd_en2, rvalid2;
    logic [63:0] raddr2, rdata2;
    logic        ready2, err2;

    param_dmem dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .ready(ready), .err(err)
    );

    param_dmem #(.RD_LAT(2), .WR_MODE(WRITE_FIRST)) dut2 (
        .clk(clk), .reset(reset2), .wr_en(wr_en2), .waddr(waddr2), .wdata(wdata2), .wbe(wbe2),
        .rd_en(rd_en2), .raddr(raddr2), .rdata(rdata2), .rvalid(rvalid2), .ready(ready2), .err(err2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[2][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic cur_rej = 1'b0;
    logic exp_err_d = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        exp_err_d <= cur_rej;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (rvalid[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("unexpected_rvalid_p%0d", k), 32'd1, 32'd0);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("rdata_p%0d", k), rdata[k*32 +: 32], e.data);
                        chk($sformatf("rvalid_cycle_p%0d", k), cyc, e.due);
                    end
                end else if (sb[k].size() != 0 && sb[k][0].due < cyc) begin
                    chk($sformatf("missing_rvalid_p%0d", k), 32'd0, 32'd1);
                    void'(sb[k].pop_front());
                end
            end
            if (err || exp_err_d) chk("err", {31'd0, err}, {31'd0, exp_err_d});
        end
    end

    task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [1:0] re, input logic [31:0] ra0,
                         input logic [31:0] ra1, input logic [1:0] ev, input logic [31:0] e0,
                         input logic [31:0] e1, input logic rej);
        wr_en   = we;
        waddr   = wa;
        wdata   = wd;
        wbe     = be;
        rd_en   = re;
        raddr   = {ra1, ra0};
        cur_rej = rej;
        if (ev[0]) sb[0].push_back('{e0, cyc + 1});
        if (ev[1]) sb[1].push_back('{e1, cyc + 1});
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 2'b00;
        wbe     = 4'h0;
        cur_rej = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic seen;
        reset = 1; wr_en = 0; waddr = 0; wdata = 0; wbe = 0; rd_en = 0; raddr = 0;
        reset2 = 1; wr_en2 = 0; waddr2 = 0; wdata2 = 0; wbe2 = 0; rd_en2 = 0; raddr2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_rvalid", {30'd0, rvalid}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rdata_lo", rdata[31:0], 0);
        chk("rst_rdata_hi", rdata[63:32], 0);
        chk("rst_ready2", {31'd0, ready2}, 0);

        reset = 0; reset2 = 0;
        n = 0;
        while (!ready && n < 400) begin
            if (n == 10) drive(0, 0, 0, 0, 2'b01, 32'h10, 0, 2'b00, 0, 0, 1);
            else @(negedge clk);
            n++;
        end
        chk("ready_latency", n, 257);

        drive(0, 0, 0, 0, 2'b11, 32'h0, 32'h3FC, 2'b11, 0, 0, 0);
        drive(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(1, 32'h10, 32'h000000AA, 4'h1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b01, 32'h10, 0, 2'b01, 32'hDEADBEAA, 0, 0);
        idle();
        idle();
        chk("hold_rvalid", {30'd0, rvalid}, 0);
        chk("hold_rdata", rdata[31:0], 32'hDEADBEAA);

        drive(1, 32'h20, 32'h11111111, 4'hF, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(1, 32'h24, 32'h22222222, 4'hF, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(1, 32'h20, 32'h12345678, 4'hF, 2'b11, 32'h20, 32'h24, 2'b11, 32'h11111111, 32'h22222222, 0);
        drive(0, 0, 0, 0, 2'b01, 32'h20, 0, 2'b01, 32'h12345678, 0, 0);

        drive(1, 32'h24, 32'hFFFFFFFF, 4'h0, 2'b10, 0, 32'h24, 2'b10, 0, 32'h22222222, 0);
        drive(0, 0, 0, 0, 2'b10, 0, 32'h24, 2'b10, 0, 32'h22222222, 0);

        drive(1, 32'h30, 32'hAABBCCDD, 4'hA, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b01, 32'h30, 0, 2'b01, 32'hAA00CC00, 0, 0);

        drive(1, 32'h400, 32'hCAFEF00D, 4'hF, 2'b11, 32'h400, 32'h400, 2'b11, 0, 0, 1);
        drive(0, 0, 0, 0, 2'b11, 32'h0, 32'h3FC, 2'b11, 0, 0, 0);

        drive(1, 32'h3FC, 32'h5A5A5A5A, 4'hF, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b10, 0, 32'h3FC, 2'b10, 0, 32'h5A5A5A5A, 0);
        drive(0, 0, 0, 0, 2'b10, 0, 32'hFFFFFFFC, 2'b10, 0, 0, 1);
        repeat (3) idle();
        chk("sb_drain_p0", sb[0].size(), 0);
        chk("sb_drain_p1", sb[1].size(), 0);

        wr_en2 = 1; waddr2 = 32'h20; wdata2 = 32'h11111111; wbe2 = 4'hF;
        @(negedge clk);
        wdata2 = 32'h12345678; rd_en2 = 2'b01; raddr2 = {32'h0, 32'h20};
        @(negedge clk);
        wr_en2 = 0; rd_en2 = 0;
        chk("wf_gap_rvalid", {30'd0, rvalid2}, 0);
        @(negedge clk);
        chk("wf_rvalid", {30'd0, rvalid2}, 32'd1);
        chk("wf_rdata", rdata2[31:0], 32'h12345678);

        wr_en2 = 1; waddr2 = 32'h24; wdata2 = 32'hAABBCCDD; wbe2 = 4'h3;
        rd_en2 = 2'b10; raddr2 = {32'h24, 32'h0};
        @(negedge clk);
        wr_en2 = 0; rd_en2 = 0;
        @(negedge clk);
        chk("wf_partial_rvalid", {30'd0, rvalid2}, 32'd2);
        chk("wf_partial_rdata", rdata2[63:32], 32'h0000CCDD);

        rd_en2 = 2'b01; raddr2 = {32'h0, 32'h20};
        @(negedge clk);
        rd_en2 = 0; reset2 = 1;
        @(negedge clk);
        seen = (rvalid2 != 0);
        reset2 = 0;
        n = 0;
        while (!ready2 && n < 400) begin
            @(negedge clk);
            n++;
            if (rvalid2 != 0) seen = 1;
        end
        chk("rst_flush_rvalid", {31'd0, seen}, 0);
        chk("rst2_ready_latency", n, 257);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
